// File: rtl/vend_dispense_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispense_arbiter
// Description : Two-requester vending dispense arbiter. Latches product and
//               change requests, serves one requester at a time with a
//               motor pulse, drop-sensor wait, optional hopper pulse, then an
//               idle gap. Missing drops lead to a FAULT state released by
//               clear_fault.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_dispense_arbiter #(
    parameter int MOTOR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int GAP_CYCLES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] prod_req,
    input  logic [1:0] change_req,
    input  logic       drop_sense,
    input  logic       clear_fault,
    output logic       motor_on,
    output logic       hopper_on,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       fault,
    output logic       ovf
);

    // Counter reload values: a counter loaded with N-1 on entry spans N cycles.
    localparam logic [7:0] C_MOTOR_LOAD   = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] C_TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] C_GAP_LOAD     = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOTOR  = 3'd1,
        S_WAIT   = 3'd2,
        S_HOPPER = 3'd3,
        S_DONE   = 3'd4,
        S_GAP    = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] r_prod_pend;
    logic [1:0] r_chg_pend;
    logic       r_drop_lat;
    logic       r_rr;
    logic       w_rr_nxt;
    logic [1:0] w_grant_nxt;
    logic [1:0] w_clr;
    logic [1:0] w_pick;
    logic       w_drop;
    logic       w_gidx;

    // A drop seen during MOTOR is remembered so it counts on WAIT entry.
    assign w_drop = r_drop_lat | drop_sense;
    assign w_gidx = grant[1];

    // Next-state, counter reload, grant selection and flag-clear decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != 8'd0) ? (r_cnt - 8'd1) : 8'd0;
        w_grant_nxt = grant;
        w_rr_nxt    = r_rr;
        w_clr       = 2'b00;
        w_pick      = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (r_prod_pend != 2'b00) begin
                    if (r_prod_pend == 2'b11) begin
                        w_pick = r_rr ? 2'b10 : 2'b01;
                    end else begin
                        w_pick = r_prod_pend;
                    end
                    w_state_nxt = S_MOTOR;
                    w_cnt_nxt   = C_MOTOR_LOAD;
                    w_grant_nxt = w_pick;
                    // Point at the requester that was not chosen.
                    w_rr_nxt    = w_pick[0];
                end
            end
            S_MOTOR: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = C_TIMEOUT_LOAD;
                end
            end
            S_WAIT: begin
                if (w_drop) begin
                    if (r_chg_pend[w_gidx]) begin
                        w_state_nxt = S_HOPPER;
                        w_cnt_nxt   = C_MOTOR_LOAD;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = 8'd0;
                    end
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = S_FAULT;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_HOPPER: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_DONE: begin
                w_clr       = grant;
                w_state_nxt = S_GAP;
                w_cnt_nxt   = C_GAP_LOAD;
                w_grant_nxt = 2'b00;
            end
            S_GAP: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    w_clr       = grant;
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = C_GAP_LOAD;
                    w_grant_nxt = 2'b00;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // State register, cycle counter, round-robin pointer and grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_rr    <= 1'b0;
            grant   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rr    <= w_rr_nxt;
            grant   <= w_grant_nxt;
        end
    end

    // Pending flags (set beats clear), sticky overflow and the drop latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_pend <= 2'b00;
            r_chg_pend  <= 2'b00;
            ovf         <= 1'b0;
            r_drop_lat  <= 1'b0;
        end else begin
            r_prod_pend <= (r_prod_pend & ~w_clr) | prod_req;
            r_chg_pend  <= (r_chg_pend & ~w_clr) | change_req;
            ovf         <= ovf | (|(prod_req & r_prod_pend)) | (|(change_req & r_chg_pend));
            if (r_state == S_IDLE) begin
                r_drop_lat <= 1'b0;
            end else if ((r_state == S_MOTOR) && drop_sense) begin
                r_drop_lat <= 1'b1;
            end
        end
    end

    // Registered drive outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            motor_on  <= 1'b0;
            hopper_on <= 1'b0;
            fault     <= 1'b0;
            done      <= 2'b00;
        end else begin
            motor_on  <= (w_state_nxt == S_MOTOR);
            hopper_on <= (w_state_nxt == S_HOPPER);
            fault     <= (w_state_nxt == S_FAULT);
            done      <= (w_state_nxt == S_DONE) ? w_grant_nxt : 2'b00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_dispense_arbiter
// Description : Self-checking bench for vend_dispense_arbiter: directed
//               scenarios followed by random traffic, all compared against a
//               procedural service-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_dispense_arbiter;

    localparam int MC = 8;
    localparam int TO = 32;
    localparam int GP = 2;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic [1:0] prod_req    = 2'b00;
    logic [1:0] change_req  = 2'b00;
    logic       drop_sense  = 1'b0;
    logic       clear_fault = 1'b0;
    logic       motor_on;
    logic       hopper_on;
    logic [1:0] grant;
    logic [1:0] done;
    logic       fault;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state: request bookkeeping and expected outputs.
    logic [1:0] m_prod    = 2'b00;
    logic [1:0] m_chg     = 2'b00;
    logic       m_ovf     = 1'b0;
    logic       m_rr      = 1'b0;
    logic       m_aborted = 1'b0;
    logic       edge_drop = 1'b0;
    logic       edge_cf   = 1'b0;
    logic       e_motor   = 1'b0;
    logic       e_hopper  = 1'b0;
    logic       e_fault   = 1'b0;
    logic [1:0] e_grant   = 2'b00;
    logic [1:0] e_done    = 2'b00;

    vend_dispense_arbiter #(
        .MOTOR_CYCLES   (MC),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prod_req    (prod_req),
        .change_req  (change_req),
        .drop_sense  (drop_sense),
        .clear_fault (clear_fault),
        .motor_on    (motor_on),
        .hopper_on   (hopper_on),
        .grant       (grant),
        .done        (done),
        .fault       (fault),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic set_out(input logic mo, input logic ho, input logic [1:0] gr,
                           input logic [1:0] dn, input logic fl);
        e_motor  = mo;
        e_hopper = ho;
        e_grant  = gr;
        e_done   = dn;
        e_fault  = fl;
    endtask

    // One clock edge of the model: request latching, ovf, optional flag clear.
    task automatic tick(input logic [1:0] clr_mask, input logic on_cf);
        logic [1:0] clr;
        @(posedge clk);
        if (!rst_n) begin
            m_prod    = 2'b00;
            m_chg     = 2'b00;
            m_ovf     = 1'b0;
            m_rr      = 1'b0;
            edge_drop = 1'b0;
            edge_cf   = 1'b0;
            m_aborted = 1'b1;
            set_out(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
            return;
        end
        edge_drop = drop_sense;
        edge_cf   = clear_fault;
        clr       = (!on_cf || clear_fault) ? clr_mask : 2'b00;
        m_ovf     = m_ovf | (|(prod_req & m_prod)) | (|(change_req & m_chg));
        m_prod    = (m_prod & ~clr) | prod_req;
        m_chg     = (m_chg & ~clr) | change_req;
    endtask

    // One complete service as a timeline; returns early if reset intervenes.
    task automatic serve_one();
        logic       who;
        logic [1:0] g;
        logic       drop;
        logic       chg_at;
        logic       fin;
        logic       to_fault;
        logic       go_hop;
        int         waited;
        m_aborted = 1'b0;
        while (m_prod == 2'b00) begin
            tick(2'b00, 1'b0);
            if (m_aborted) return;
        end
        who  = (m_prod == 2'b11) ? m_rr : m_prod[1];
        m_rr = ~who;
        g    = who ? 2'b10 : 2'b01;
        tick(2'b00, 1'b0);
        if (m_aborted) return;
        set_out(1'b1, 1'b0, g, 2'b00, 1'b0);
        drop = 1'b0;
        repeat (MC) begin
            tick(2'b00, 1'b0);
            if (m_aborted) return;
            drop = drop | edge_drop;
        end
        set_out(1'b0, 1'b0, g, 2'b00, 1'b0);
        waited   = 0;
        fin      = 1'b0;
        to_fault = 1'b0;
        go_hop   = 1'b0;
        while (!fin) begin
            chg_at = m_chg[who];
            tick(2'b00, 1'b0);
            if (m_aborted) return;
            waited++;
            if (drop || edge_drop) begin
                fin    = 1'b1;
                go_hop = chg_at;
            end else if (waited == TO) begin
                fin      = 1'b1;
                to_fault = 1'b1;
            end
        end
        if (to_fault) begin
            set_out(1'b0, 1'b0, g, 2'b00, 1'b1);
            do begin
                tick(g, 1'b1);
                if (m_aborted) return;
            end while (!edge_cf);
        end else begin
            if (go_hop) begin
                set_out(1'b0, 1'b1, g, 2'b00, 1'b0);
                repeat (MC) begin
                    tick(2'b00, 1'b0);
                    if (m_aborted) return;
                end
            end
            set_out(1'b0, 1'b0, g, g, 1'b0);
            tick(g, 1'b0);
            if (m_aborted) return;
        end
        set_out(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        repeat (GP) begin
            tick(2'b00, 1'b0);
            if (m_aborted) return;
        end
    endtask

    initial begin : ref_model
        forever serve_one();
    end

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("motor_on",  {1'b0, motor_on},  {1'b0, e_motor});
        chk("hopper_on", {1'b0, hopper_on}, {1'b0, e_hopper});
        chk("grant",     grant,             e_grant);
        chk("done",      done,              e_done);
        chk("fault",     {1'b0, fault},     {1'b0, e_fault});
        chk("ovf",       {1'b0, ovf},       {1'b0, m_ovf});
        chk("no_overlap", {1'b0, motor_on & hopper_on}, 2'b00);
    endtask

    // Present inputs for one cycle, then check outputs on the falling edge.
    task automatic cyc(input logic [1:0] pr, input logic [1:0] cr,
                       input logic ds, input logic cf);
        prod_req    = pr;
        change_req  = cr;
        drop_sense  = ds;
        clear_fault = cf;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_motor", {1'b0, motor_on},  2'b00);
        chk("rst_hopper", {1'b0, hopper_on}, 2'b00);
        chk("rst_grant", grant, 2'b00);
        chk("rst_done",  done,  2'b00);
        chk("rst_fault_ovf", {fault, ovf}, 2'b00);
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int         n_done0;
        logic [1:0] pr;
        logic [1:0] cr;
        logic       ds;
        logic       cf;

        // Power-up reset
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        chk("reset_grant", grant, 2'b00);
        chk("reset_ovf", {1'b0, ovf}, 2'b00);
        rst_n = 1'b1;
        cyc(2'b00, 2'b00, 1'b0, 1'b0);

        // Basic product service with drop during MOTOR
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            cyc(2'b00, 2'b00, (k == 6), 1'b0);
            if (k == 1)  chk("basic_grant_c1", grant, 2'b01);
            if (k == 8)  chk("basic_motor_c8", {1'b0, motor_on}, 2'b01);
            if (k == 9)  chk("basic_motor_c9", {1'b0, motor_on}, 2'b00);
            if (k == 10) chk("basic_done_c10", done, 2'b01);
            if (k == 11) chk("basic_grant_c11", grant, 2'b00);
        end

        // Product plus change: hopper follows WAIT
        cyc(2'b01, 2'b01, 1'b0, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            cyc(2'b00, 2'b00, (k == 3), 1'b0);
            if (k == 10) chk("chg_hopper_c10", {1'b0, hopper_on}, 2'b01);
            if (k == 17) chk("chg_hopper_c17", {1'b0, hopper_on}, 2'b01);
            if (k == 18) chk("chg_done_c18", done, 2'b01);
        end

        // Simultaneous requests after reset: requester 0 first
        do_reset();
        cyc(2'b11, 2'b00, 1'b0, 1'b0);
        for (int k = 1; k <= 27; k++) begin
            cyc(2'b00, 2'b00, (k == 4) || (k == 18), 1'b0);
            if (k == 10) chk("rr_done0_c10", done, 2'b01);
            if (k == 14) chk("rr_grant1_c14", grant, 2'b10);
            if (k == 23) chk("rr_done1_c23", done, 2'b10);
        end

        // Timeout into FAULT, request during FAULT, clear_fault
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        for (int k = 1; k <= 62; k++) begin
            cyc((k == 43) ? 2'b01 : 2'b00, 2'b00, (k == 52), (k == 46));
            if (k == 40) chk("fault_c40", {1'b0, fault}, 2'b00);
            if (k == 41) chk("fault_c41", {1'b0, fault}, 2'b01);
            if (k == 45) chk("fault_grant_held", grant, 2'b10);
            if (k == 46) chk("fault_clear_nodone", done, 2'b00);
            if (k == 49) chk("fault_next_grant", grant, 2'b01);
            if (k == 58) chk("fault_next_done", done, 2'b01);
        end

        // Duplicate request sets ovf and is served once
        n_done0 = 0;
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            cyc((k == 1) ? 2'b01 : 2'b00, 2'b00, (k == 4), 1'b0);
            if (done[0]) n_done0++;
            if (k == 2) chk("ovf_set", {1'b0, ovf}, 2'b01);
        end
        chk("ovf_single_service", 2'(n_done0), 2'b01);

        // Reset during MOTOR aborts service
        cyc(2'b01, 2'b00, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 1'b0, 1'b0);
        chk("pre_abort_motor", {1'b0, motor_on}, 2'b01);
        do_reset();
        cyc(2'b10, 2'b00, 1'b0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            cyc(2'b00, 2'b00, (k == 3), 1'b0);
            if (k == 10) chk("post_reset_done", done, 2'b10);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            pr = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cr = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (i < 1500) ds = ($urandom_range(0, 5) == 0);
            else          ds = ($urandom_range(0, 59) == 0);
            cf = ($urandom_range(0, 9) == 0);
            if (i == 2200) do_reset();
            cyc(pr, cr, ds, cf);
        end
        cyc(2'b00, 2'b00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
